// File: rtl/ov7670_sccb_cfg_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : ov7670_sccb_cfg_seq_if
// Description : Config-LUT and SCCB pad bundle for the OV7670 config sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface ov7670_sccb_cfg_seq_if;
    logic [7:0]  lut_index;
    logic [15:0] lut_data;
    logic        sccb_scl;
    logic        sccb_sda_oe;
    logic        sccb_sda_i;

    modport master (
        output lut_index,
        output sccb_scl,
        output sccb_sda_oe,
        input  lut_data,
        input  sccb_sda_i
    );

    modport slave (
        input  lut_index,
        input  sccb_scl,
        input  sccb_sda_oe,
        output lut_data,
        output sccb_sda_i
    );
endinterface
`default_nettype wire

// File: rtl/ov7670_sccb_cfg_seq.sv
`default_nettype none
// ============================================================================
// Module      : ov7670_sccb_cfg_seq
// Description : Walks the OV7670 config LUT, one 3-phase SCCB write per entry.
// Revision    : 1.0 - initial release
// ============================================================================
module ov7670_sccb_cfg_seq #(
    parameter logic [7:0] DEV_ID    = 8'h42,
    parameter int         LUT_START = 2,
    parameter int         LUT_SIZE  = 165,
    parameter int         QTR_CYC   = 63,
    parameter int         WAIT_CYC  = 500000
) (
    input  wire                          clk,
    input  wire                          rst_n,
    input  wire                          start,
    ov7670_sccb_cfg_seq_if.master        bus,
    output logic                         cfg_busy,
    output logic                         cfg_done,
    output logic                         nack_err
);

    localparam int              c_qw    = (QTR_CYC > 1) ? $clog2(QTR_CYC) : 1;
    localparam int              c_ww    = $clog2(WAIT_CYC + 1);
    localparam logic [c_qw-1:0] c_qmax  = c_qw'(QTR_CYC - 1);
    localparam logic [c_ww-1:0] c_wmax  = c_ww'(WAIT_CYC - 1);
    localparam logic [7:0]      c_first = 8'(LUT_START);
    localparam logic [7:0]      c_last  = 8'(LUT_START + LUT_SIZE - 1);

    typedef enum logic [2:0] {
        S_PWRUP = 3'd0,
        S_LOAD  = 3'd1,
        S_START = 3'd2,
        S_BITS  = 3'd3,
        S_STOP  = 3'd4,
        S_GAP   = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [c_ww-1:0] r_wait_cnt;
    logic [c_qw-1:0] r_qcnt;
    logic [1:0]      r_quarter;
    logic [4:0]      r_slot;
    logic [26:0]     r_shift;
    logic [7:0]      r_index;
    logic            r_busy;
    logic            r_done;
    logic            r_nack;
    logic            r_scl_prev;
    logic            r_sda_prev;
    logic            w_qtick;
    logic            w_phase_end;
    logic            w_ack_slot;
    logic            w_scl;
    logic            w_sda;
    logic            w_sda_out;
    logic            w_start_ok;

    assign w_qtick     = (r_qcnt == c_qmax);
    assign w_phase_end = w_qtick && (r_quarter == 2'd3);
    assign w_ack_slot  = (r_slot == 5'd8) || (r_slot == 5'd17) || (r_slot == 5'd26);
    assign w_start_ok  = (r_state == S_DONE) && start;

    // SDA follows one cycle late whenever SCL toggles, so the two pads never move together.
    assign w_sda_out       = (w_scl != r_scl_prev) ? r_sda_prev : w_sda;
    assign bus.sccb_scl    = w_scl;
    assign bus.sccb_sda_oe = w_sda_out;
    assign bus.lut_index   = r_index;
    assign cfg_busy        = r_busy;
    assign cfg_done        = r_done;
    assign nack_err        = r_nack;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_PWRUP;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_scl       = 1'b1;
        w_sda       = 1'b0;
        case (r_state)
            S_PWRUP: begin
                if (r_wait_cnt == c_wmax) w_state_nxt = S_LOAD;
            end
            S_LOAD: begin
                w_state_nxt = S_START;
            end
            S_START: begin
                w_scl = (r_quarter != 2'd3);
                w_sda = (r_quarter != 2'd0);
                if (w_phase_end) w_state_nxt = S_BITS;
            end
            S_BITS: begin
                w_scl = r_quarter[1];
                w_sda = ~r_shift[26];
                if (w_phase_end && (r_slot == 5'd26)) w_state_nxt = S_STOP;
            end
            S_STOP: begin
                w_scl = r_quarter[1];
                w_sda = (r_quarter != 2'd3);
                if (w_phase_end) w_state_nxt = S_GAP;
            end
            S_GAP: begin
                if (w_phase_end) w_state_nxt = (r_index == c_last) ? S_DONE : S_LOAD;
            end
            S_DONE: begin
                if (start) w_state_nxt = S_PWRUP;
            end
            default: begin
                w_state_nxt = S_PWRUP;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wait_cnt <= '0;
            r_qcnt     <= '0;
            r_quarter  <= 2'd0;
            r_slot     <= 5'd0;
            r_shift    <= '1;
            r_index    <= c_first;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_nack     <= 1'b0;
            r_scl_prev <= 1'b1;
            r_sda_prev <= 1'b0;
        end else begin
            r_busy     <= (w_state_nxt != S_DONE);
            r_done     <= (w_state_nxt == S_DONE);
            r_scl_prev <= w_scl;
            r_sda_prev <= w_sda_out;

            if (r_state == S_PWRUP) r_wait_cnt <= r_wait_cnt + c_ww'(1);
            else                    r_wait_cnt <= '0;

            if ((r_state == S_PWRUP) || (r_state == S_LOAD) || (r_state == S_DONE)) begin
                r_qcnt    <= '0;
                r_quarter <= 2'd0;
            end else if (w_qtick) begin
                r_qcnt    <= '0;
                r_quarter <= r_quarter + 2'd1;
            end else begin
                r_qcnt    <= r_qcnt + c_qw'(1);
            end

            // Each 9th bit is loaded as 1 so the master releases SDA for the ACK slot.
            if (r_state == S_LOAD) begin
                r_shift <= {DEV_ID, 1'b1, bus.lut_data[15:8], 1'b1, bus.lut_data[7:0], 1'b1};
                r_slot  <= 5'd0;
            end else if ((r_state == S_BITS) && w_phase_end) begin
                r_shift <= {r_shift[25:0], 1'b1};
                r_slot  <= r_slot + 5'd1;
            end

            if (w_start_ok) begin
                r_index <= c_first;
            end else if ((r_state == S_GAP) && w_phase_end && (r_index != c_last)) begin
                r_index <= r_index + 8'd1;
            end

            if (w_start_ok) begin
                r_nack <= 1'b0;
            end else if ((r_state == S_BITS) && w_ack_slot && (r_quarter == 2'd2) &&
                         w_qtick && bus.sccb_sda_i) begin
                r_nack <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ov7670_sccb_cfg_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_ov7670_sccb_cfg_seq
// Description : Directed bench with an SCCB slave decoder for the config sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ov7670_sccb_cfg_seq;

    logic clk;
    logic rst_n;
    logic start;
    logic cfg_busy;
    logic cfg_done;
    logic nack_err;
    logic slave_oe;
    int   edge_cnt;

    int errors = 0;
    int checks = 0;

    ov7670_sccb_cfg_seq_if bus ();

    ov7670_sccb_cfg_seq #(
        .DEV_ID    (8'h42),
        .LUT_START (2),
        .LUT_SIZE  (3),
        .QTR_CYC   (2),
        .WAIT_CYC  (10)
    ) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .bus      (bus),
        .cfg_busy (cfg_busy),
        .cfg_done (cfg_done),
        .nack_err (nack_err)
    );

    assign bus.sccb_sda_i = ~(bus.sccb_sda_oe | slave_oe);
    assign bus.lut_data   = (bus.lut_index == 8'd2) ? 16'h1214 :
                            (bus.lut_index == 8'd3) ? 16'h40d0 :
                            (bus.lut_index == 8'd4) ? 16'h3a04 : 16'hffff;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) edge_cnt <= 0;
        else        edge_cnt <= edge_cnt + 1;
    end

    logic [7:0]  exp_bytes [9] = '{8'h42, 8'h12, 8'h14, 8'h42, 8'h40, 8'hd0, 8'h42, 8'h3a, 8'h04};
    logic [7:0]  rx_q [$];
    int          start_log [$];
    logic [31:0] idx_log [$];
    logic        prev_valid = 1'b0;
    logic        prev_scl, prev_sda, prev_oe;
    logic [7:0]  prev_idx;
    logic        in_xfer = 1'b0;
    int          bitcnt = 0;
    logic [7:0]  sh;
    int          byte_total = 0;
    int          nack_byte = -1;
    int          same_chg = 0;
    int          done_cyc;
    int          base;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    // One negedge: SCCB slave decode/ACK plus index and pad-change monitors.
    task automatic tick();
        logic scl, sda;
        @(negedge clk);
        scl = bus.sccb_scl;
        sda = bus.sccb_sda_i;
        if (rst_n) begin
            if (prev_valid) begin
                if (scl && prev_scl && prev_sda && !sda) begin
                    in_xfer = 1'b1;
                    bitcnt  = 0;
                    start_log.push_back(edge_cnt);
                end else if (scl && prev_scl && !prev_sda && sda) begin
                    in_xfer = 1'b0;
                end else if (in_xfer && scl && !prev_scl) begin
                    if (bitcnt < 8) sh = {sh[6:0], sda};
                    bitcnt++;
                end else if (in_xfer && !scl && prev_scl) begin
                    if (bitcnt == 8) begin
                        rx_q.push_back(sh);
                        slave_oe = (byte_total != nack_byte);
                        byte_total++;
                    end else if (bitcnt == 9) begin
                        slave_oe = 1'b0;
                        bitcnt   = 0;
                    end
                end
                if ((scl != prev_scl) && (bus.sccb_sda_oe != prev_oe)) same_chg++;
                if (bus.lut_index != prev_idx) idx_log.push_back({24'(edge_cnt), bus.lut_index});
            end
            prev_valid = 1'b1;
        end else begin
            prev_valid = 1'b0;
            slave_oe   = 1'b0;
        end
        prev_scl = scl;
        prev_sda = sda;
        prev_oe  = bus.sccb_sda_oe;
        prev_idx = bus.lut_index;
    endtask

    task automatic wait_edge(input int n);
        int g = 0;
        while ((edge_cnt < n) && (g < 5000)) begin
            tick();
            g++;
        end
    endtask

    task automatic wait_done(output int cyc);
        int g = 0;
        while (!cfg_done && (g < 2000)) begin
            tick();
            g++;
        end
        check("done_seen", 32'(cfg_done), 32'd1);
        cyc = edge_cnt;
    endtask

    task automatic check_run(input string tag, input int b);
        check({tag, "_rx_count"}, 32'(rx_q.size()), 32'd9);
        for (int i = 0; i < 9; i++) begin
            if (i < rx_q.size()) check($sformatf("%s_rx_byte%0d", tag, i), 32'(rx_q[i]), 32'(exp_bytes[i]));
        end
        check({tag, "_start_count"}, 32'(start_log.size()), 32'd3);
        for (int i = 0; i < 3; i++) begin
            if (i < start_log.size()) check($sformatf("%s_start_cyc%0d", tag, i),
                                            32'(start_log[i] - b), 32'(13 + 241 * i));
        end
        check({tag, "_idx_changes"}, 32'(idx_log.size()), 32'd2);
        if (idx_log.size() >= 2) begin
            check({tag, "_idx3_at"}, idx_log[0], {24'(b + 251), 8'd3});
            check({tag, "_idx4_at"}, idx_log[1], {24'(b + 492), 8'd4});
        end
    endtask

    task automatic clear_logs();
        rx_q.delete();
        start_log.delete();
        idx_log.delete();
        byte_total = 0;
    endtask

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        slave_oe = 1'b0;
        repeat (3) tick();
        check("rst_scl", 32'(bus.sccb_scl), 32'd1);
        check("rst_sda_oe", 32'(bus.sccb_sda_oe), 32'd0);
        check("rst_index", 32'(bus.lut_index), 32'd2);
        check("rst_busy", 32'(cfg_busy), 32'd0);
        check("rst_done", 32'(cfg_done), 32'd0);
        check("rst_nack", 32'(nack_err), 32'd0);

        // Run 1: reg byte of the first entry is NACKed; a start pulse mid-run is ignored.
        clear_logs();
        nack_byte = 1;
        rst_n     = 1'b1;
        tick();
        check("busy_after_release", 32'(cfg_busy), 32'd1);
        wait_edge(12);
        check("sda_before_start", 32'(bus.sccb_sda_oe), 32'd0);
        tick();
        check("start_sda_low", 32'(bus.sccb_sda_oe), 32'd1);
        check("start_scl_high", 32'(bus.sccb_scl), 32'd1);
        wait_edge(100);
        check("nack_before", 32'(nack_err), 32'd0);
        wait_edge(200);
        check("nack_set", 32'(nack_err), 32'd1);
        wait_edge(300);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("busy_start_ignored", 32'(cfg_done), 32'd0);
        check("busy_start_index", 32'(bus.lut_index), 32'd3);
        wait_done(done_cyc);
        check("run1_done_cyc", 32'(done_cyc), 32'd733);
        check("run1_nack_sticky", 32'(nack_err), 32'd1);
        check("run1_busy_low", 32'(cfg_busy), 32'd0);
        check_run("run1", 0);
        repeat (20) tick();
        check("done_index_hold", 32'(bus.lut_index), 32'd4);
        check("done_hold", 32'(cfg_done), 32'd1);

        // Run 2: start accepted in DONE, clean resend.
        clear_logs();
        nack_byte = -1;
        start = 1'b1;
        tick();
        start = 1'b0;
        base  = edge_cnt;
        idx_log.delete();
        check("accept_done_clr", 32'(cfg_done), 32'd0);
        check("accept_nack_clr", 32'(nack_err), 32'd0);
        check("accept_busy", 32'(cfg_busy), 32'd1);
        check("accept_index", 32'(bus.lut_index), 32'd2);
        wait_done(done_cyc);
        check("run2_done_cyc", 32'(done_cyc - base), 32'd733);
        check("run2_nack", 32'(nack_err), 32'd0);
        check_run("run2", base);

        // Run 3: reset asserted inside the data byte of the second entry.
        clear_logs();
        start = 1'b1;
        tick();
        start = 1'b0;
        base  = edge_cnt;
        wait_edge(base + 421);
        check("pre_rst_index", 32'(bus.lut_index), 32'd3);
        check("pre_rst_scl", 32'(bus.sccb_scl), 32'd0);
        check("pre_rst_sda_oe", 32'(bus.sccb_sda_oe), 32'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_scl", 32'(bus.sccb_scl), 32'd1);
        check("midrst_sda_oe", 32'(bus.sccb_sda_oe), 32'd0);
        check("midrst_index", 32'(bus.lut_index), 32'd2);
        check("midrst_busy", 32'(cfg_busy), 32'd0);
        check("midrst_done", 32'(cfg_done), 32'd0);
        repeat (2) tick();
        clear_logs();
        rst_n = 1'b1;
        wait_done(done_cyc);
        check("run3_done_cyc", 32'(done_cyc), 32'd733);
        check_run("run3", 0);

        check("scl_sda_same_cycle", 32'(same_chg), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
